// File: rtl/simple_risc_pkg.sv
// Shared widths and enums for the simple RISC memory path.
package simple_risc_pkg;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} mau_state_e;
    typedef enum logic [1:0] {REQ_RD, REQ_WR, REQ_PUSH, REQ_POP} req_kind_e;
endpackage

// File: rtl/stack_ptr.sv
// Downward-growing stack pointer with full/empty flags and a sticky misuse flag.
module stack_ptr
    import simple_risc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_BASE  = 9'h1FF,
    parameter int                STACK_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_commit,
    input  logic              pop_commit,
    input  logic              err_set,
    output logic [ADDR_W-1:0] sp,
    output logic              full,
    output logic              empty,
    output logic              err
);
    logic [ADDR_W-1:0] used;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp  <= STACK_BASE;
            err <= 1'b0;
        end else begin
            if (push_commit)
                sp <= sp - 9'd1;
            else if (pop_commit)
                sp <= sp + 9'd1;
            if (err_set)
                err <= 1'b1;
        end
    end

    assign used  = STACK_BASE - sp;
    assign full  = (used == ADDR_W'(STACK_DEPTH));
    assign empty = (sp == STACK_BASE);
endmodule

// File: rtl/mem_access_unit.sv
// Load/store and stack push/pop sequencer in front of a synchronous RAM.
// Hardware stack is present only when MEM_ACCESS_STACK_EN is defined.
module mem_access_unit
    import simple_risc_pkg::*;
#(
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 9'h1FF,
    parameter int                STACK_DEPTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic              sread,
    input  logic              swrite,
    input  logic [ADDR_W-1:0] mar,
    input  logic [DATA_W-1:0] mdr_in,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              stack_err,
    output logic              req_err,
    output mau_state_e        dbg_state
);
    // Handshake: request lines are levels; a 0->1 edge seen in IDLE is accepted,
    // and mem_ready is a single-cycle completion pulse in DONE.
    mau_state_e        state, state_nx;
    req_kind_e         kind, kind_nx;
    logic [3:0]        req_now, req_prev, rise;  // {write, read, swrite, sread}
    logic [2:0]        cnt;
    logic              skip, skip_nx, accept, multi, last_access;
    logic [ADDR_W-1:0] addr_nx;

`ifdef MEM_ACCESS_STACK_EN
    assign req_now = {write, read, swrite, sread};
`else
    assign req_now = {write, read, swrite & 1'b0, sread & 1'b0};
`endif

    assign rise        = req_now & ~req_prev;
    assign accept      = (state == ST_IDLE) && (rise != 4'b0000);
    assign multi       = ((rise & (rise - 4'd1)) != 4'b0000);
    assign last_access = (state == ST_ACCESS) && (cnt == 3'(WAIT_STATES));
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = ST_ACCESS;
            ST_ACCESS: if (last_access) state_nx = ST_DONE;
            ST_DONE:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        ram_we    = last_access && !skip && (kind == REQ_WR || kind == REQ_PUSH);
        mem_ready = (state == ST_DONE);
    end

    // Priority write > read > push > pop when several lines rise together.
    always_comb begin
        kind_nx = REQ_POP;
        if (rise[3])      kind_nx = REQ_WR;
        else if (rise[2]) kind_nx = REQ_RD;
        else if (rise[1]) kind_nx = REQ_PUSH;
        addr_nx = mar;
        if (kind_nx == REQ_PUSH)     addr_nx = sp;
        else if (kind_nx == REQ_POP) addr_nx = sp + 9'd1;
        skip_nx = (kind_nx == REQ_PUSH && stack_full) || (kind_nx == REQ_POP && stack_empty);
    end

    // Request-edge history resets high so a line held through reset needs a fresh edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_prev     <= 4'b1111;
            cnt          <= 3'd0;
            kind         <= REQ_RD;
            skip         <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            mem_data_out <= '0;
            req_err      <= 1'b0;
        end else begin
            req_prev <= req_now;
            cnt      <= (state == ST_ACCESS) ? cnt + 3'd1 : 3'd0;
            if (accept) begin
                kind      <= kind_nx;
                skip      <= skip_nx;
                ram_addr  <= addr_nx;
                ram_wdata <= mdr_in;
            end
            if (last_access && (kind == REQ_RD || kind == REQ_POP))
                mem_data_out <= skip ? '0 : ram_rdata;
            if ((accept && multi) || (state != ST_IDLE && rise != 4'b0000))
                req_err <= 1'b1;
        end
    end

`ifdef MEM_ACCESS_STACK_EN
    logic push_commit, pop_commit, err_set;
    assign push_commit = last_access && !skip && (kind == REQ_PUSH);
    assign pop_commit  = last_access && !skip && (kind == REQ_POP);
    assign err_set     = last_access && skip;

    stack_ptr #(
        .STACK_BASE  (STACK_BASE),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack_ptr (
        .clk         (clk),
        .reset       (reset),
        .push_commit (push_commit),
        .pop_commit  (pop_commit),
        .err_set     (err_set),
        .sp          (sp),
        .full        (stack_full),
        .empty       (stack_empty),
        .err         (stack_err)
    );
`else
    assign sp          = STACK_BASE;
    assign stack_full  = 1'b0;
    assign stack_empty = 1'b1;
    assign stack_err   = 1'b0;
`endif
endmodule
